// File: rtl/wb_byte_resp_pkg.sv
// Shared definitions for the wishbone byte responder: register map,
// STATUS bit layout, CTRL layout and response-register states.
package wb_byte_resp_pkg;

   localparam logic [2:0] REG_DATA   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;
   localparam logic [2:0] REG_CLR    = 3'd3;

   localparam int ST_RX_NOT_EMPTY = 0;
   localparam int ST_TX_NOT_FULL  = 1;
   localparam int ST_RX_OVERFLOW  = 2;
   localparam int ST_TX_EMPTY     = 3;
   localparam int ST_RX_COUNT_LSB = 8;
   localparam int ST_TX_COUNT_LSB = 16;

   localparam int CLR_RX_OVF_BIT = 2;

   // Packed MSB-first, so rx_irq_en lands on bit 0.
   typedef struct packed {
      logic tx_irq_en;
      logic rx_irq_en;
   } ctrl_t;

   typedef enum logic {
      RS_IDLE = 1'b0,
      RS_RESP = 1'b1
   } resp_state_e;

endpackage

// File: rtl/wishbone.sv
// Wishbone classic bus bundle with master and slave views.
interface wishbone #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dat_w;
   logic [3:0]        sel;
   logic [DATA_W-1:0] dat_r;
   logic              ack;
   logic              err;

   modport slave  (input  cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
   modport master (output cyc, stb, we, adr, dat_w, sel, input  dat_r, ack, err);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wb_byte_responder.sv
// Wishbone classic responder: DATA writes feed a TX byte stream, DATA reads
// drain an RX byte stream, with STATUS/CTRL/CLR and a level interrupt.
module wb_byte_responder
   import wb_byte_resp_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   wishbone.slave     wb_slave,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       interrupt
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   resp_state_e       state_q, state_d;
   logic              ack_q, ack_d, err_q, err_d;
   logic [DATA_W-1:0] dat_r_q, dat_r_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic              ovf_q, ovf_clr, irq_q;
   logic [CNT_W-1:0]  stall_q;
   logic              req;
   logic [2:0]        idx;
   logic [DATA_W-1:0] status;

   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [CNT_W-1:0] tx_count, rx_count;
   logic [7:0]       rx_rdata;
   logic             unused_bits;

   assign unused_bits = ^{wb_slave.adr[1:0], wb_slave.dat_w[DATA_W-1:8], wb_slave.sel[3:1]};

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(wb_slave.dat_w[7:0]),
      .rdata(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_data),
      .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & rx_ready;

   // Requests are only taken in IDLE, which is exactly when ack and err are low.
   assign idx = wb_slave.adr[4:2];
   assign req = wb_slave.cyc & wb_slave.stb & (state_q == RS_IDLE);

   always_comb begin
      status = '0;
      status[ST_RX_NOT_EMPTY] = ~rx_empty;
      status[ST_TX_NOT_FULL]  = ~tx_full;
      status[ST_RX_OVERFLOW]  = ovf_q;
      status[ST_TX_EMPTY]     = tx_empty;
      status[ST_RX_COUNT_LSB +: CNT_W] = rx_count;
      status[ST_TX_COUNT_LSB +: CNT_W] = tx_count;
   end

   always_comb begin
      state_d = RS_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_r_d = '0;
      ctrl_d  = ctrl_q;
      ovf_clr = 1'b0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      if (req) begin
         state_d = RS_RESP;
         if (idx[2]) begin
            err_d = 1'b1;
         end else begin
            ack_d = 1'b1;
            case (idx)
               REG_DATA: begin
                  if (wb_slave.we) begin
                     tx_push = wb_slave.sel[0];
                  end else if (!rx_empty) begin
                     rx_pop  = 1'b1;
                     dat_r_d = DATA_W'(rx_rdata);
                  end
               end
               REG_STATUS: if (!wb_slave.we) dat_r_d = status;
               REG_CTRL: begin
                  if (!wb_slave.we)         dat_r_d = DATA_W'(ctrl_q);
                  else if (wb_slave.sel[0]) ctrl_d  = ctrl_t'(wb_slave.dat_w[1:0]);
               end
               REG_CLR: ovf_clr = wb_slave.we & wb_slave.sel[0] & wb_slave.dat_w[CLR_RX_OVF_BIT];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RS_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_r_q <= '0;
         ctrl_q  <= '0;
         ovf_q   <= 1'b0;
         stall_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_r_q <= dat_r_d;
         ctrl_q  <= ctrl_d;
         irq_q   <= (ctrl_q.rx_irq_en & ~rx_empty) | (ctrl_q.tx_irq_en & tx_empty);
         // Overflow flags a producer stalled longer than the FIFO could ever absorb.
         if (rx_valid & rx_full) begin
            if (stall_q == CNT_W'(FIFO_DEPTH)) ovf_q <= 1'b1;
            else                               stall_q <= stall_q + 1'b1;
         end else begin
            stall_q <= '0;
         end
         if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign wb_slave.ack   = ack_q;
   assign wb_slave.err   = err_q;
   assign wb_slave.dat_r = dat_r_q;
   assign interrupt      = irq_q;

endmodule

// File: tb/tb_wb_byte_responder.sv
// Directed bench for wb_byte_responder: register-access vector table plus
// hand-written TX drain, RX backpressure, overflow, interrupt and reset sequences.
module tb_wb_byte_responder;
   import wb_byte_resp_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       interrupt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wishbone #(.ADDR_W(5), .DATA_W(32)) wb ();

   wb_byte_responder #(.ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .wb_slave(wb),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .interrupt(interrupt)
   );

   typedef struct {
      logic        we;
      logic [2:0]  idx;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic        exp_ack;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_access(input logic we, input logic [2:0] idx, input logic [31:0] wdata,
                            input logic [3:0] sel, output logic a, output logic e,
                            output logic [31:0] r);
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
      wb.adr = {idx, 2'b00}; wb.dat_w = wdata; wb.sel = sel;
      step();
      a = wb.ack; e = wb.err; r = wb.dat_r;
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
      step();
      check("resp_one_cycle", {30'b0, wb.ack, wb.err}, 32'h0);
   endtask

   task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input string name);
      logic a, e;
      logic [31:0] r;
      wb_access(1'b1, idx, d, 4'hF, a, e, r);
      check({name, "_ack"}, {31'b0, a}, 32'h1);
   endtask

   task automatic wb_read(input logic [2:0] idx, input logic [31:0] exp, input string name);
      logic a, e;
      logic [31:0] r;
      wb_access(1'b0, idx, 32'h0, 4'hF, a, e, r);
      check({name, "_ack"}, {31'b0, a}, 32'h1);
      check(name, r, exp);
   endtask

   task automatic rx_fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_data  = base + 8'(i);
         check("rx_ready_fill", {31'b0, rx_ready}, 32'h1);
         step();
      end
   endtask

   initial begin
      logic a, e;
      logic [31:0] r;

      //             we    idx         wdata          sel   ack   err   rdata
      vecs[0]  = '{1'b0, REG_STATUS, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_000A};
      vecs[1]  = '{1'b1, REG_CTRL,   32'h3,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, REG_CTRL,   32'h0,         4'hF, 1'b1, 1'b0, 32'h3};
      vecs[3]  = '{1'b1, REG_CTRL,   32'h2,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 3'd5,       32'h3,         4'hF, 1'b0, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 3'd5,       32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 3'd7,       32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, REG_CTRL,   32'h0,         4'hF, 1'b1, 1'b0, 32'h2};
      vecs[8]  = '{1'b0, REG_CLR,    32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, REG_STATUS, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b1, REG_DATA,   32'h99,        4'hE, 1'b1, 1'b0, 32'h0};
      vecs[11] = '{1'b0, REG_DATA,   32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[12] = '{1'b0, REG_STATUS, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_000A};
      vecs[13] = '{1'b1, REG_CTRL,   32'h0,         4'hF, 1'b1, 1'b0, 32'h0};

      // clock/reset
      rst = 1'b1;
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
      wb.adr = '0; wb.dat_w = '0; wb.sel = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_ack",       {31'b0, wb.ack},    32'h0);
      check("rst_err",       {31'b0, wb.err},    32'h0);
      check("rst_dat_r",     wb.dat_r,           32'h0);
      check("rst_tx_valid",  {31'b0, tx_valid},  32'h0);
      check("rst_rx_ready",  {31'b0, rx_ready},  32'h1);
      check("rst_interrupt", {31'b0, interrupt}, 32'h0);

      // register-access vectors
      for (int i = 0; i < 14; i++) begin
         wb_access(vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].sel, a, e, r);
         check($sformatf("vec%0d_ack", i),   {31'b0, a}, {31'b0, vecs[i].exp_ack});
         check($sformatf("vec%0d_err", i),   {31'b0, e}, {31'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_rdata", i), r,          vecs[i].exp_rdata);
         if (i == 12) check("irq_tx_empty", {31'b0, interrupt}, 32'h1);
      end
      check("irq_off_after_ctrl0", {31'b0, interrupt}, 32'h0);

      // TX: queue three bytes, then drain on consecutive cycles
      wb_write(REG_DATA, 32'h41, "tx_w41");
      wb_write(REG_DATA, 32'h42, "tx_w42");
      wb_write(REG_DATA, 32'h43, "tx_w43");
      wb_read(REG_STATUS, 32'h0003_0002, "tx_status3");
      check("tx_valid_q", {31'b0, tx_valid}, 32'h1);
      tx_ready = 1'b1;
      check("tx_d0", {24'b0, tx_data}, 32'h41);
      step();
      check("tx_d1", {24'b0, tx_data}, 32'h42);
      step();
      check("tx_d2", {24'b0, tx_data}, 32'h43);
      step();
      check("tx_drained", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // RX: fill, backpressure, one pop frees a slot for the held byte
      rx_fill(8'h00, 16);
      rx_data = 8'hFF;
      check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
      wb_read(REG_DATA, 32'h00, "rx_pop0");
      rx_valid = 1'b0;
      wb_read(REG_STATUS, 32'h0000_100B, "rx_status16");
      check("rx_ready_refull", {31'b0, rx_ready}, 32'h0);
      for (int i = 1; i < 16; i++) wb_read(REG_DATA, 32'(i), "rx_pop_seq");
      wb_read(REG_DATA, 32'hFF, "rx_pop_ff");
      wb_read(REG_DATA, 32'h0, "rx_empty_read");
      wb_read(REG_STATUS, 32'h0000_000A, "rx_status_empty");

      // RX overflow boundary: 16 stalled cycles is fine, 17 sets the flag
      rx_fill(8'h20, 16);
      repeat (16) step();
      rx_valid = 1'b0;
      wb_read(REG_STATUS, 32'h0000_100B, "ovf_16_clear");
      rx_valid = 1'b1;
      repeat (17) step();
      rx_valid = 1'b0;
      wb_read(REG_STATUS, 32'h0000_100F, "ovf_17_set");
      wb_write(REG_CLR, 32'h4, "ovf_clr");
      wb_read(REG_STATUS, 32'h0000_100B, "ovf_cleared");
      for (int i = 0; i < 16; i++) wb_read(REG_DATA, 32'h20 + 32'(i), "ovf_drain");

      // interrupt on RX data
      wb_write(REG_CTRL, 32'h1, "irq_ctrl");
      check("irq_idle", {31'b0, interrupt}, 32'h0);
      rx_data = 8'h55; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      check("irq_before", {31'b0, interrupt}, 32'h0);
      step();
      check("irq_rise", {31'b0, interrupt}, 32'h1);
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = {REG_DATA, 2'b00}; wb.sel = 4'hF;
      step();
      check("irq_pop_ack",  {31'b0, wb.ack},    32'h1);
      check("irq_pop_data", wb.dat_r,           32'h55);
      check("irq_held",     {31'b0, interrupt}, 32'h1);
      wb.cyc = 1'b0; wb.stb = 1'b0;
      step();
      check("irq_fall",     {31'b0, interrupt}, 32'h0);
      check("irq_ack_drop", {31'b0, wb.ack},    32'h0);
      wb_write(REG_CTRL, 32'h0, "irq_ctrl_off");

      // TX full drop, then reset in the middle of a drain
      wb_write(REG_CTRL, 32'h3, "pre_rst_ctrl");
      for (int i = 0; i < 16; i++) wb_write(REG_DATA, 32'h10 + 32'(i), "tx_fill");
      wb_write(REG_DATA, 32'hEE, "tx_full_drop");
      wb_read(REG_STATUS, 32'h0010_0000, "tx_status_full");
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_drain", {24'b0, tx_data}, 32'h10 + 32'(i));
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tx_ready = 1'b0;
      check("mid_rst_tx_valid", {31'b0, tx_valid},  32'h0);
      check("mid_rst_rx_ready", {31'b0, rx_ready},  32'h1);
      check("mid_rst_irq",      {31'b0, interrupt}, 32'h0);
      check("mid_rst_ack",      {31'b0, wb.ack},    32'h0);
      wb_read(REG_STATUS, 32'h0000_000A, "post_rst_status");
      wb_read(REG_CTRL,   32'h0,         "post_rst_ctrl");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
